wbs_ann_slave: RTL and testbench

Wishbone B4 classic slave that terminates all Caravel management-SoC accesses to the ANN accelerator. Decodes the 32-bit address map into control/status registers and SRAM-style ports for the query, leaf, node and best-match arrays. Assembles 64-bit query/leaf words from lower/upper 32-bit writes, and splits 64-bit best-array reads into two 32-bit reads. Sits between the Wishbone pins of `user_proj_example` and the accelerator core/memories.

---
 rtl/wbs_ann_pkg.sv | 43 ++++
 rtl/wbs_addr_decode.sv | 52 +++++
 rtl/wbs_ann_slave.sv | 251 +++++++++++++++++++++++++
 tb/tb_wbs_ann_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wbs_ann_pkg.sv
// Shared constants and types for the ANN accelerator Wishbone slave:
// region bases, CSR offsets, decode enums and the bus FSM state type.
package wbs_ann_pkg;

  localparam logic [31:0] ADDR_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] BASE_CSR   = 32'h3000_0000;
  localparam logic [31:0] BASE_QUERY = 32'h3001_0000;
  localparam logic [31:0] BASE_LEAF  = 32'h3002_0000;
  localparam logic [31:0] BASE_BEST  = 32'h3003_0000;
  localparam logic [31:0] BASE_NODE  = 32'h3004_0000;

  localparam logic [15:0] CSR_OFF_MODE  = 16'h0000;
  localparam logic [15:0] CSR_OFF_DEBUG = 16'h0004;
  localparam logic [15:0] CSR_OFF_DONE  = 16'h0008;
  localparam logic [15:0] CSR_OFF_START = 16'h000C;
  localparam logic [15:0] CSR_OFF_BUSY  = 16'h0010;

  typedef enum logic [2:0] {
    REGION_CSR,
    REGION_QUERY,
    REGION_LEAF,
    REGION_BEST,
    REGION_NODE,
    REGION_NONE
  } region_e;

  typedef enum logic [2:0] {
    CSR_MODE,
    CSR_DEBUG,
    CSR_DONE,
    CSR_START,
    CSR_BUSY,
    CSR_NONE
  } csr_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_RD_ISSUE,
    ST_RD_CAPT
  } state_e;

endpackage

// File: rtl/wbs_addr_decode.sv
// Combinational decode of a Wishbone address into region, CSR register
// and the per-array word addresses.
module wbs_addr_decode
  import wbs_ann_pkg::*;
#(
  parameter int QUERY_AW = 9,
  parameter int LEAF_AW  = 11,
  parameter int NODE_AW  = 6,
  parameter int BEST_AW  = 9
) (
  input  logic [31:0]         adr_i,
  output region_e             region_o,
  output csr_e                csr_o,
  output logic [QUERY_AW-1:0] query_word_o,
  output logic [LEAF_AW-1:0]  leaf_word_o,
  output logic [NODE_AW-1:0]  node_word_o,
  output logic [BEST_AW-1:0]  best_word_o,
  output logic                upper_o
);

  always_comb begin
    region_o = REGION_NONE;
    case (adr_i & ADDR_MASK)
      BASE_CSR:   region_o = REGION_CSR;
      BASE_QUERY: region_o = REGION_QUERY;
      BASE_LEAF:  region_o = REGION_LEAF;
      BASE_BEST:  region_o = REGION_BEST;
      BASE_NODE:  region_o = REGION_NODE;
      default:    region_o = REGION_NONE;
    endcase
  end

  always_comb begin
    csr_o = CSR_NONE;
    case (adr_i[15:0])
      CSR_OFF_MODE:  csr_o = CSR_MODE;
      CSR_OFF_DEBUG: csr_o = CSR_DEBUG;
      CSR_OFF_DONE:  csr_o = CSR_DONE;
      CSR_OFF_START: csr_o = CSR_START;
      CSR_OFF_BUSY:  csr_o = CSR_BUSY;
      default:       csr_o = CSR_NONE;
    endcase
  end

  // 64-bit arrays use byte address bit 2 as the half select.
  assign query_word_o = adr_i[QUERY_AW+2:3];
  assign leaf_word_o  = adr_i[LEAF_AW+2:3];
  assign best_word_o  = adr_i[BEST_AW+2:3];
  assign node_word_o  = adr_i[NODE_AW+1:2];
  assign upper_o      = adr_i[2];

endmodule

// File: rtl/wbs_ann_slave.sv
// Wishbone B4 classic slave fronting the ANN accelerator: CSRs, 64-bit
// query/leaf write assembly, node writes and split 64-bit best-array reads.
module wbs_ann_slave
  import wbs_ann_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int QUERY_AW   = 9,
  parameter int LEAF_AW    = 11,
  parameter int NODE_AW    = 6,
  parameter int BEST_AW    = 9
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    mode_o,
  output logic                    debug_o,
  output logic                    fsm_start_o,
  input  logic                    fsm_done_i,
  input  logic                    fsm_busy_i,
  output logic                    query_we_o,
  output logic [QUERY_AW-1:0]     query_addr_o,
  output logic [63:0]             query_wdata_o,
  output logic                    leaf_we_o,
  output logic [LEAF_AW-1:0]      leaf_addr_o,
  output logic [63:0]             leaf_wdata_o,
  output logic                    node_we_o,
  output logic [NODE_AW-1:0]      node_addr_o,
  output logic [2*DATA_WIDTH-1:0] node_wdata_o,
  output logic                    best_re_o,
  output logic [BEST_AW-1:0]      best_addr_o,
  input  logic [63:0]             best_rdata_i
);

  localparam int NW = 2*DATA_WIDTH;

  region_e             region;
  csr_e                csr;
  logic [QUERY_AW-1:0] query_word;
  logic [LEAF_AW-1:0]  leaf_word;
  logic [NODE_AW-1:0]  node_word;
  logic [BEST_AW-1:0]  best_word;
  logic                upper;

  wbs_addr_decode #(
    .QUERY_AW (QUERY_AW),
    .LEAF_AW  (LEAF_AW),
    .NODE_AW  (NODE_AW),
    .BEST_AW  (BEST_AW)
  ) u_decode (
    .adr_i        (wbs_adr_i),
    .region_o     (region),
    .csr_o        (csr),
    .query_word_o (query_word),
    .leaf_word_o  (leaf_word),
    .node_word_o  (node_word),
    .best_word_o  (best_word),
    .upper_o      (upper)
  );

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                mode_q, mode_d;
  logic                debug_q, debug_d;
  logic                start_q, start_d;
  logic [31:0]         hold_q, hold_d;
  logic                query_we_q, query_we_d;
  logic [QUERY_AW-1:0] query_addr_q, query_addr_d;
  logic [63:0]         query_wdata_q, query_wdata_d;
  logic                leaf_we_q, leaf_we_d;
  logic [LEAF_AW-1:0]  leaf_addr_q, leaf_addr_d;
  logic [63:0]         leaf_wdata_q, leaf_wdata_d;
  logic                node_we_q, node_we_d;
  logic [NODE_AW-1:0]  node_addr_q, node_addr_d;
  logic [NW-1:0]       node_wdata_q, node_wdata_d;
  logic                best_re_q, best_re_d;
  logic [BEST_AW-1:0]  best_addr_q, best_addr_d;
  logic                half_q, half_d;

  logic        req;
  logic        wr_en;
  logic [31:0] csr_rdata;

  assign req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_en = wbs_we_i & (|wbs_sel_i);

  always_comb begin
    csr_rdata = '0;
    case (csr)
      CSR_MODE:  csr_rdata[0] = mode_q;
      CSR_DEBUG: csr_rdata[0] = debug_q;
      CSR_DONE:  csr_rdata[0] = fsm_done_i;
      CSR_BUSY:  csr_rdata[0] = fsm_busy_i;
      default:   csr_rdata = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ack_d         = 1'b0;
    dat_d         = dat_q;
    mode_d        = mode_q;
    debug_d       = debug_q;
    start_d       = 1'b0;
    hold_d        = hold_q;
    query_we_d    = 1'b0;
    query_addr_d  = query_addr_q;
    query_wdata_d = query_wdata_q;
    leaf_we_d     = 1'b0;
    leaf_addr_d   = leaf_addr_q;
    leaf_wdata_d  = leaf_wdata_q;
    node_we_d     = 1'b0;
    node_addr_d   = node_addr_q;
    node_wdata_d  = node_wdata_q;
    best_re_d     = 1'b0;
    best_addr_d   = best_addr_q;
    half_d        = half_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!wbs_we_i && region == REGION_BEST) begin
            state_d     = ST_RD_ISSUE;
            best_re_d   = 1'b1;
            best_addr_d = best_word;
            half_d      = upper;
          end else begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            dat_d   = (!wbs_we_i && region == REGION_CSR) ? csr_rdata : '0;
            if (wr_en) begin
              case (region)
                REGION_CSR: begin
                  if (csr == CSR_MODE)  mode_d  = wbs_dat_i[0];
                  if (csr == CSR_DEBUG) debug_d = wbs_dat_i[0];
                  if (csr == CSR_START) start_d = wbs_dat_i[0];
                end
                REGION_QUERY: begin
                  if (upper) begin
                    query_we_d    = 1'b1;
                    query_addr_d  = query_word;
                    query_wdata_d = {wbs_dat_i, hold_q};
                  end else begin
                    hold_d = wbs_dat_i;
                  end
                end
                REGION_LEAF: begin
                  if (upper) begin
                    leaf_we_d    = 1'b1;
                    leaf_addr_d  = leaf_word;
                    leaf_wdata_d = {wbs_dat_i, hold_q};
                  end else begin
                    hold_d = wbs_dat_i;
                  end
                end
                REGION_NODE: begin
                  node_we_d    = 1'b1;
                  node_addr_d  = node_word;
                  node_wdata_d = wbs_dat_i[NW-1:0];
                end
                default: ;
              endcase
            end
          end
        end
      end
      ST_ACK: state_d = ST_IDLE;
      // An abandoned cycle drops the outstanding best read silently.
      ST_RD_ISSUE: state_d = wbs_cyc_i ? ST_RD_CAPT : ST_IDLE;
      ST_RD_CAPT: begin
        if (wbs_cyc_i) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          dat_d   = half_q ? best_rdata_i[63:32] : best_rdata_i[31:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      ack_q         <= 1'b0;
      dat_q         <= '0;
      mode_q        <= 1'b0;
      debug_q       <= 1'b0;
      start_q       <= 1'b0;
      hold_q        <= '0;
      query_we_q    <= 1'b0;
      query_addr_q  <= '0;
      query_wdata_q <= '0;
      leaf_we_q     <= 1'b0;
      leaf_addr_q   <= '0;
      leaf_wdata_q  <= '0;
      node_we_q     <= 1'b0;
      node_addr_q   <= '0;
      node_wdata_q  <= '0;
      best_re_q     <= 1'b0;
      best_addr_q   <= '0;
      half_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      dat_q         <= dat_d;
      mode_q        <= mode_d;
      debug_q       <= debug_d;
      start_q       <= start_d;
      hold_q        <= hold_d;
      query_we_q    <= query_we_d;
      query_addr_q  <= query_addr_d;
      query_wdata_q <= query_wdata_d;
      leaf_we_q     <= leaf_we_d;
      leaf_addr_q   <= leaf_addr_d;
      leaf_wdata_q  <= leaf_wdata_d;
      node_we_q     <= node_we_d;
      node_addr_q   <= node_addr_d;
      node_wdata_q  <= node_wdata_d;
      best_re_q     <= best_re_d;
      best_addr_q   <= best_addr_d;
      half_q        <= half_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign mode_o        = mode_q;
  assign debug_o       = debug_q;
  assign fsm_start_o   = start_q;
  assign query_we_o    = query_we_q;
  assign query_addr_o  = query_addr_q;
  assign query_wdata_o = query_wdata_q;
  assign leaf_we_o     = leaf_we_q;
  assign leaf_addr_o   = leaf_addr_q;
  assign leaf_wdata_o  = leaf_wdata_q;
  assign node_we_o     = node_we_q;
  assign node_addr_o   = node_addr_q;
  assign node_wdata_o  = node_wdata_q;
  assign best_re_o     = best_re_q;
  assign best_addr_o   = best_addr_q;

endmodule

// File: tb/tb_wbs_ann_slave.sv
// Directed self-checking bench for wbs_ann_slave.
module tb_wbs_ann_slave;

  localparam int DW = 11;
  localparam int QAW = 9;
  localparam int LAW = 11;
  localparam int NAW = 6;
  localparam int BAW = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]      sel = 4'h0;
  logic [31:0]     adr = '0, wdat = '0;
  logic            ack;
  logic [31:0]     rdat;
  logic            mode, debug, start;
  logic            done = 1'b0, busy = 1'b0;
  logic            q_we;
  logic [QAW-1:0]  q_addr;
  logic [63:0]     q_wdata;
  logic            l_we;
  logic [LAW-1:0]  l_addr;
  logic [63:0]     l_wdata;
  logic            n_we;
  logic [NAW-1:0]  n_addr;
  logic [2*DW-1:0] n_wdata;
  logic            b_re;
  logic [BAW-1:0]  b_addr;
  logic [63:0]     b_rdata = '0;

  int checks = 0;
  int errors = 0;

  wbs_ann_slave #(
    .DATA_WIDTH (DW),
    .QUERY_AW   (QAW),
    .LEAF_AW    (LAW),
    .NODE_AW    (NAW),
    .BEST_AW    (BAW)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (rdat),
    .mode_o        (mode),
    .debug_o       (debug),
    .fsm_start_o   (start),
    .fsm_done_i    (done),
    .fsm_busy_i    (busy),
    .query_we_o    (q_we),
    .query_addr_o  (q_addr),
    .query_wdata_o (q_wdata),
    .leaf_we_o     (l_we),
    .leaf_addr_o   (l_addr),
    .leaf_wdata_o  (l_wdata),
    .node_we_o     (n_we),
    .node_addr_o   (n_addr),
    .node_wdata_o  (n_wdata),
    .best_re_o     (b_re),
    .best_addr_o   (b_addr),
    .best_rdata_i  (b_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read model of the best array: word 7 holds a known value.
  always @(posedge clk)
    if (b_re) b_rdata <= (b_addr == 9'd7) ? 64'hDEAD_BEEF_0000_0123 : 64'h0BAD_0BAD_0BAD_0BAD;

  // Pulse monitors: sampled at the edge, so a one-cycle pulse counts once.
  int          start_cnt = 0, leaf_cnt = 0, query_cnt = 0, node_cnt = 0, bre_cnt = 0;
  logic [LAW-1:0]  leaf_addr_s;
  logic [63:0]     leaf_wd_s;
  logic [QAW-1:0]  query_addr_s;
  logic [63:0]     query_wd_s;
  logic [NAW-1:0]  node_addr_s;
  logic [2*DW-1:0] node_wd_s;
  logic [BAW-1:0]  best_addr_s;

  always @(posedge clk) begin
    if (start) start_cnt++;
    if (l_we) begin leaf_cnt++;  leaf_addr_s = l_addr;  leaf_wd_s = l_wdata; end
    if (q_we) begin query_cnt++; query_addr_s = q_addr; query_wd_s = q_wdata; end
    if (n_we) begin node_cnt++;  node_addr_s = n_addr;  node_wd_s = n_wdata; end
    if (b_re) begin bre_cnt++;   best_addr_s = b_addr; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int n);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 20);
    check({tag, " ack"}, 64'(ack), 64'd1);
    rd = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({tag, " ack_len"}, 64'(ack), 64'd0);
  endtask

  logic [31:0] rd;
  int          n, c0, acks;
  logic        prev_ack, dbl;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst ack", 64'(ack), 0);
    check("rst mode", 64'(mode), 0);
    check("rst start", 64'(start), 0);
    check("rst leaf_wdata", l_wdata, 0);
    check("rst best_re", 64'(b_re), 0);
    check("rst dat_o", 64'(rdat), 0);
    rst = 1'b0;

    // CSR MODE / DEBUG
    xfer("wr mode", 1, 32'h3000_0000, 32'h1, 4'hF, rd, n);
    check("wr mode lat", 64'(n), 1);
    check("mode_o", 64'(mode), 1);
    xfer("rd mode", 0, 32'h3000_0000, 0, 4'hF, rd, n);
    check("rd mode data", 64'(rd), 64'h1);
    xfer("wr debug", 1, 32'h3000_0004, 32'h1, 4'h1, rd, n);
    xfer("wr debug sel0", 1, 32'h3000_0004, 32'h0, 4'h0, rd, n);
    check("debug kept on sel0", 64'(debug), 1);
    xfer("rd debug", 0, 32'h3000_0004, 0, 4'hF, rd, n);
    check("rd debug data", 64'(rd), 64'h1);

    // Start pulse, DONE/BUSY status
    c0 = start_cnt;
    xfer("wr start", 1, 32'h3000_000C, 32'h1, 4'hF, rd, n);
    check("start pulses", 64'(start_cnt - c0), 1);
    c0 = start_cnt;
    xfer("wr start0", 1, 32'h3000_000C, 32'h0, 4'hF, rd, n);
    check("start0 pulses", 64'(start_cnt - c0), 0);
    xfer("rd start", 0, 32'h3000_000C, 0, 4'hF, rd, n);
    check("rd start data", 64'(rd), 0);
    done = 1'b1;
    xfer("rd done", 0, 32'h3000_0008, 0, 4'hF, rd, n);
    check("rd done data", 64'(rd), 64'h1);
    busy = 1'b1;
    xfer("rd busy", 0, 32'h3000_0010, 0, 4'hF, rd, n);
    check("rd busy data", 64'(rd), 64'h1);
    xfer("rd csr other", 0, 32'h3000_0014, 0, 4'hF, rd, n);
    check("rd csr other data", 64'(rd), 0);

    // Leaf assembly
    c0 = leaf_cnt;
    xfer("leaf lo", 1, 32'h3002_0028, 32'hAAAA_5555, 4'hF, rd, n);
    check("leaf lo no we", 64'(leaf_cnt - c0), 0);
    xfer("leaf hi", 1, 32'h3002_002C, 32'h0123_4567, 4'hF, rd, n);
    check("leaf hi we", 64'(leaf_cnt - c0), 1);
    check("leaf addr", 64'(leaf_addr_s), 5);
    check("leaf wdata", leaf_wd_s, 64'h0123_4567_AAAA_5555);
    xfer("leaf hi again", 1, 32'h3002_002C, 32'h89AB_CDEF, 4'hF, rd, n);
    check("leaf hold kept", leaf_wd_s, 64'h89AB_CDEF_AAAA_5555);
    xfer("rd leaf", 0, 32'h3002_0028, 0, 4'hF, rd, n);
    check("rd leaf data", 64'(rd), 0);

    // Query assembly
    c0 = query_cnt;
    xfer("query lo", 1, 32'h3001_0010, 32'h1111_2222, 4'hF, rd, n);
    xfer("query hi", 1, 32'h3001_0014, 32'h3333_4444, 4'hF, rd, n);
    check("query we", 64'(query_cnt - c0), 1);
    check("query addr", 64'(query_addr_s), 2);
    check("query wdata", query_wd_s, 64'h3333_4444_1111_2222);

    // Node writes
    c0 = node_cnt;
    xfer("node wr", 1, 32'h3004_0008, {10'd0, 11'd55, 11'd1}, 4'hF, rd, n);
    check("node we", 64'(node_cnt - c0), 1);
    check("node addr", 64'(node_addr_s), 2);
    check("node wdata", 64'(node_wd_s), 64'h1B801);
    xfer("node wr trunc", 1, 32'h3004_0010, 32'hFFC1_B801, 4'hF, rd, n);
    check("node addr2", 64'(node_addr_s), 4);
    check("node wdata trunc", 64'(node_wd_s), 64'h1B801);

    // Best reads
    c0 = bre_cnt;
    xfer("best lo", 0, 32'h3003_0038, 0, 4'hF, rd, n);
    check("best lo data", 64'(rd), 64'h0000_0123);
    check("best lo lat", 64'(n), 3);
    check("best addr", 64'(best_addr_s), 7);
    xfer("best hi", 0, 32'h3003_003C, 0, 4'hF, rd, n);
    check("best hi data", 64'(rd), 64'hDEAD_BEEF);
    check("best re count", 64'(bre_cnt - c0), 2);

    // Unmapped region
    xfer("unmapped wr", 1, 32'h3005_0000, 32'h0, 4'hF, rd, n);
    check("unmapped no effect", 64'(mode), 1);
    xfer("unmapped rd", 0, 32'h3005_0000, 0, 4'hF, rd, n);
    check("unmapped rd data", 64'(rd), 0);

    // Held strobe: one ack per accepted request, never two in a row
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; wdat = 32'h1; sel = 4'hF;
    acks = 0; prev_ack = 1'b0; dbl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
      if (ack && prev_ack) dbl = 1'b1;
      prev_ack = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("held stb acks", 64'(acks), 4);
    check("held stb no double", 64'(dbl), 0);
    @(posedge clk); #1;

    // Reset during RD_CAPT
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3003_0038;
    @(posedge clk); #1;
    check("rdcapt best_re", 64'(b_re), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst ack", 64'(ack), 0);
    check("midrst mode", 64'(mode), 0);
    check("midrst best_re", 64'(b_re), 0);
    check("midrst best_addr", 64'(b_addr), 0);
    check("midrst leaf_wdata", l_wdata, 0);
    check("midrst dat_o", 64'(rdat), 0);
    @(posedge clk); #1;
    check("midrst no ack", 64'(ack), 0);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b0;
    xfer("post rst rd mode", 0, 32'h3000_0000, 0, 4'hF, rd, n);
    check("post rst mode data", 64'(rd), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
